instr_sequencer: RTL

- Upstream feeder for the CPU control unit.
- Fetches 8-bit instruction words, plus the immediate word for MVI, from a synchronous-read program memory.
- Presents each instruction and its immediate to the control unit, pulses run, and waits for done before advancing the PC.
- Stops at a programmable length. A watchdog flags a control unit that never completes.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/seq_watchdog.sv | 29 ++
 rtl/instr_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode values, instruction field positions and sequencer states.
package cpu_pkg;

    localparam logic [1:0] OP_MVI = 2'b00;
    localparam logic [1:0] OP_CPY = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RX_HI  = 5;
    localparam int RX_LO  = 3;
    localparam int RY_HI  = 2;
    localparam int RY_LO  = 0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_I    = 3'd2,
        S_FETCH_IMM = 3'd3,
        S_WAIT_IMM  = 3'd4,
        S_ISSUE     = 3'd5,
        S_EXEC      = 3'd6,
        S_ERR       = 3'd7
    } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Clearable saturating cycle counter; expire_o flags the cycle that completes TIMEOUT increments.
module seq_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != CW'(TIMEOUT))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The current increment is the TIMEOUT-th one when the count already holds TIMEOUT-1.
    assign expire_o = (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Fetches instructions (plus MVI immediates) from program memory and hands them to the
// control unit one at a time, waiting for done before moving on.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int N       = 8,
    parameter int AW      = 6,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    output logic          pm_en,
    output logic [AW-1:0] pm_addr,
    input  logic [N-1:0]  pm_rdata,
    output logic [N-1:0]  instruction,
    output logic [N-1:0]  data_in,
    output logic          run,
    input  logic          done,
    output logic          busy,
    output logic          prog_done,
    output logic          err,
    output logic [AW:0]   pc
);

    seq_state_t    state_q, state_d;
    logic [AW:0]   pc_q, pc_d, len_q, len_d, pc_inc;
    logic [N-1:0]  instr_q, instr_d, data_q, data_d;
    logic [AW-1:0] pm_addr_q;
    logic          pd_q, pd_d;
    logic          wd_clr, wd_inc, wd_expire;

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wd_clr),
        .inc_i    (wd_inc),
        .expire_o (wd_expire)
    );

    assign pc_inc = pc_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            instr_q   <= '0;
            data_q    <= '0;
            pm_addr_q <= '0;
            pd_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            pd_q    <= pd_d;
            if (pm_en) begin
                pm_addr_q <= pc_q[AW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        instr_d = instr_q;
        data_d  = data_q;
        pd_d    = 1'b0;
        pm_en   = 1'b0;
        run     = 1'b0;
        wd_clr  = 1'b0;
        wd_inc  = 1'b0;
        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    len_d = prog_len;
                    pc_d  = '0;
                    if (prog_len == '0) begin
                        pd_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                pm_en   = 1'b1;
                state_d = S_WAIT_I;
            end
            S_WAIT_I: begin
                instr_d = pm_rdata;
                pc_d    = pc_inc;
                // An MVI in the last word has no immediate to fetch.
                if (pm_rdata[OPC_HI:OPC_LO] == OP_MVI) begin
                    state_d = (pc_inc == len_q) ? S_ERR : S_FETCH_IMM;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FETCH_IMM: begin
                pm_en   = 1'b1;
                state_d = S_WAIT_IMM;
            end
            S_WAIT_IMM: begin
                data_d  = pm_rdata;
                pc_d    = pc_inc;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                run     = 1'b1;
                wd_clr  = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                wd_inc = 1'b1;
                if (done) begin
                    if (pc_q >= len_q) begin
                        pd_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (wd_expire) begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pm_addr     = pm_en ? pc_q[AW-1:0] : pm_addr_q;
    assign instruction = instr_q;
    assign data_in     = data_q;
    assign prog_done   = pd_q;
    assign pc          = pc_q;
    assign err         = (state_q == S_ERR);
    assign busy        = (state_q != S_IDLE) && (state_q != S_ERR);

endmodule
